// File: rtl/mdio_master.sv
// Clause-22 MDIO management master: serialises one read or write command at a
// time onto MDC/MDIO and returns a single-cycle completion response.
module mdio_master #(
    parameter int DIV         = 25,
    parameter bit PREAMBLE_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_phy_addr,
    input  logic [4:0]  cmd_reg_addr,
    input  logic [15:0] cmd_data,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_error,
    output logic        mdc_o,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_t
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_HDR,
        S_TA,
        S_DATA,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [DIV_W-1:0]  div_cnt;
    logic [5:0]        bit_cnt;
    logic [5:0]        seg_last_idx;
    logic [31:0]       tx_shift;
    logic [31:0]       tx_src;
    logic [31:0]       frame;
    logic [15:0]       rx_shift;
    logic              is_read;
    logic              rd_src;
    logic              ta_err;
    logic              accept;
    logic              half_end;
    logic              bit_end;
    logic              seg_last;
    logic              load_bit;

    assign accept   = (state == S_IDLE) && cmd_valid && cmd_ready;
    assign half_end = (div_cnt == DIV_W'(DIV - 1));
    assign bit_end  = half_end && mdc_o;

    // Everything after the preamble: ST, OP, PHYAD, REGAD, TA, DATA. Reads fill
    // TA/DATA with ones since the line is released for those bits anyway.
    assign frame = {2'b01,
                    cmd_write ? 2'b01 : 2'b10,
                    cmd_phy_addr,
                    cmd_reg_addr,
                    cmd_write ? 2'b10 : 2'b11,
                    cmd_write ? cmd_data : 16'hFFFF};

    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
        state_nxt    = state;
        seg_last_idx = 6'd0;
        tx_src       = accept ? frame : tx_shift;
        rd_src       = accept ? !cmd_write : is_read;

        case (state)
            S_PRE:   seg_last_idx = 6'd31;
            S_HDR:   seg_last_idx = 6'd13;
            S_TA:    seg_last_idx = 6'd1;
            S_DATA:  seg_last_idx = 6'd15;
            default: seg_last_idx = 6'd0;
        endcase
        seg_last = (bit_cnt == seg_last_idx);

        case (state)
            S_IDLE:  if (accept) state_nxt = PREAMBLE_EN ? S_PRE : S_HDR;
            S_PRE:   if (bit_end && seg_last) state_nxt = S_HDR;
            S_HDR:   if (bit_end && seg_last) state_nxt = S_TA;
            S_TA:    if (bit_end && seg_last) state_nxt = S_DATA;
            S_DATA:  if (bit_end && seg_last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        // A new bit period starts on accept and on every bit end except the last.
        load_bit = accept || (bit_end && (state_nxt != S_DONE));
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 16'h0000;
            rsp_error <= 1'b0;
            mdc_o     <= 1'b0;
            mdio_o    <= 1'b1;
            mdio_t    <= 1'b1;
            div_cnt   <= '0;
            bit_cnt   <= 6'd0;
            tx_shift  <= 32'h0;
            rx_shift  <= 16'h0000;
            is_read   <= 1'b0;
            ta_err    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cmd_ready <= (state_nxt == S_IDLE);
            rsp_valid <= (state_nxt == S_DONE);

            if (state == S_PRE || state == S_HDR || state == S_TA || state == S_DATA) begin
                if (half_end) begin
                    div_cnt <= '0;
                    mdc_o   <= ~mdc_o;
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
            end else begin
                div_cnt <= '0;
                mdc_o   <= 1'b0;
            end

            if (accept) begin
                is_read <= !cmd_write;
                bit_cnt <= 6'd0;
            end else if (bit_end) begin
                bit_cnt <= seg_last ? 6'd0 : bit_cnt + 6'd1;
            end

            if (load_bit) begin
                if (state_nxt == S_PRE) begin
                    mdio_o   <= 1'b1;
                    tx_shift <= tx_src;
                end else begin
                    mdio_o   <= tx_src[31];
                    tx_shift <= {tx_src[30:0], 1'b0};
                end
                mdio_t <= rd_src && (state_nxt == S_TA || state_nxt == S_DATA);
            end else if (state_nxt == S_DONE) begin
                mdio_o <= 1'b1;
                mdio_t <= 1'b1;
            end

            // MDIO is sampled on the clk edge that raises MDC.
            if (half_end && !mdc_o) begin
                if (state == S_TA && bit_cnt == 6'd1) ta_err <= mdio_i;
                if (state == S_DATA) rx_shift <= {rx_shift[14:0], mdio_i};
            end

            if (state_nxt == S_DONE) begin
                rsp_data  <= is_read ? rx_shift : 16'h0000;
                rsp_error <= is_read && ta_err;
            end
        end
    end

endmodule

// File: tb/tb_mdio_master.sv
// Bench for mdio_master: directed and randomised frames on a default instance
// plus a short no-preamble DIV=2 instance, checked against a frame-level model.
module tb_mdio_master;

    logic clk = 1'b0;
    always #4 clk = ~clk;

    logic        reset_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [4:0]  cmd_phy_addr, cmd_reg_addr;
    logic [15:0] cmd_data;
    logic        rsp_valid, rsp_error;
    logic [15:0] rsp_data;
    logic        mdc_o, mdio_o, mdio_t;
    logic        mdio_i = 1'b1;

    logic        cmd_valid_b, cmd_ready_b, cmd_write_b;
    logic [4:0]  cmd_phy_addr_b, cmd_reg_addr_b;
    logic [15:0] cmd_data_b;
    logic        rsp_valid_b, rsp_error_b;
    logic [15:0] rsp_data_b;
    logic        mdc_o_b, mdio_o_b, mdio_t_b;
    logic        mdio_i_b;

    mdio_master dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
        .mdc_o(mdc_o), .mdio_i(mdio_i), .mdio_o(mdio_o), .mdio_t(mdio_t)
    );

    mdio_master #(.DIV(2), .PREAMBLE_EN(1'b0)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_write(cmd_write_b),
        .cmd_phy_addr(cmd_phy_addr_b), .cmd_reg_addr(cmd_reg_addr_b), .cmd_data(cmd_data_b),
        .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b), .rsp_error(rsp_error_b),
        .mdc_o(mdc_o_b), .mdio_i(mdio_i_b), .mdio_o(mdio_o_b), .mdio_t(mdio_t_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Frame monitor and PHY model for the default instance.
    int          cyc = 0, acc_cyc = 0, rsp_cyc = 0, rsp_cnt = 0, nbits = 0;
    logic [63:0] cap_o = '0, cap_t = '0;
    logic        mdc_prev = 1'b0, acc_a;
    bit          phy_read = 1'b0, phy_present = 1'b0;
    logic [15:0] phy_resp = 16'h0000;

    // Bits 0..31 preamble, 32..45 header, 46..47 turnaround, 48..63 data.
    function automatic logic phy_bit(input int idx);
        if (!phy_read || !phy_present) return 1'b1;
        if (idx == 47) return 1'b0;
        if (idx >= 48 && idx < 64) return phy_resp[63 - idx];
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        acc_a = cmd_valid && cmd_ready;
        if (acc_a) begin
            acc_cyc = cyc;
            nbits   = 0;
            cap_o   = '0;
            cap_t   = '0;
        end
        #1;
        cyc++;
        if (mdc_o && !mdc_prev) begin
            cap_o = {cap_o[62:0], mdio_o};
            cap_t = {cap_t[62:0], mdio_t};
            nbits++;
        end
        mdc_prev = mdc_o;
        if (!mdc_o) mdio_i = phy_bit(nbits);
        if (rsp_valid) begin
            rsp_cnt++;
            rsp_cyc = cyc;
        end
    end

    // Frame monitor for the DIV=2, no-preamble instance.
    int          cyc_b = 0, acc_cyc_b = 0, rsp_cyc_b = 0, nbits_b = 0, last_rise_b = 0, rise_gap_b = 0;
    logic [31:0] cap_b = '0;
    logic        mdc_prev_b = 1'b0, acc_b;

    always @(posedge clk) begin
        acc_b = cmd_valid_b && cmd_ready_b;
        if (acc_b) begin
            acc_cyc_b = cyc_b;
            nbits_b   = 0;
            cap_b     = '0;
        end
        #1;
        cyc_b++;
        if (mdc_o_b && !mdc_prev_b) begin
            cap_b       = {cap_b[30:0], mdio_o_b};
            nbits_b++;
            rise_gap_b  = cyc_b - last_rise_b;
            last_rise_b = cyc_b;
        end
        mdc_prev_b = mdc_o_b;
        if (rsp_valid_b) rsp_cyc_b = cyc_b;
    end

    task automatic issue(input bit wr, input logic [4:0] pa, input logic [4:0] ra,
                         input logic [15:0] d, input string tag);
        int n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, cmd_ready, 1'b1);
        cmd_write    = wr;
        cmd_phy_addr = pa;
        cmd_reg_addr = ra;
        cmd_data     = d;
        cmd_valid    = 1'b1;
        @(negedge clk);
        cmd_valid    = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        int n = 0;
        while (!rsp_valid && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_rsp_seen"}, rsp_valid, 1'b1);
    endtask

    // Called during the DONE cycle, while the captured frame is still intact.
    task automatic check_frame(input bit wr, input logic [4:0] pa, input logic [4:0] ra,
                               input logic [15:0] d, input bit present, input logic [15:0] resp,
                               input string tag);
        logic [45:0] exp_hdr;
        exp_hdr = {32'hFFFF_FFFF, 2'b01, (wr ? 2'b01 : 2'b10), pa, ra};
        check({tag, "_latency"}, rsp_cyc - acc_cyc, 3201);
        check({tag, "_nbits"}, nbits, 64);
        check({tag, "_hdr"}, cap_o[63:18], exp_hdr);
        if (wr) begin
            check({tag, "_ta_data"}, cap_o[17:0], {2'b10, d});
            check({tag, "_mdio_t"}, cap_t, 64'h0);
            check({tag, "_rsp_data"}, rsp_data, 16'h0000);
            check({tag, "_rsp_error"}, rsp_error, 1'b0);
        end else begin
            check({tag, "_mdio_t"}, cap_t, 64'h3FFFF);
            check({tag, "_rsp_data"}, rsp_data, present ? resp : 16'hFFFF);
            check({tag, "_rsp_error"}, rsp_error, !present);
        end
    endtask

    task automatic run_frame(input bit wr, input logic [4:0] pa, input logic [4:0] ra,
                             input logic [15:0] d, input bit present, input logic [15:0] resp,
                             input string tag);
        int start;
        phy_read    = !wr;
        phy_present = present;
        phy_resp    = resp;
        start       = rsp_cnt;
        issue(wr, pa, ra, d, tag);
        wait_rsp(tag);
        check_frame(wr, pa, ra, d, present, resp, tag);
        @(negedge clk);
        check({tag, "_ready_after"}, cmd_ready, 1'b1);
        check({tag, "_one_pulse"}, rsp_cnt - start, 1);
        check({tag, "_pulse_low"}, rsp_valid, 1'b0);
    endtask

    initial begin
        logic [4:0]  pa, ra, pa2, ra2;
        logic [15:0] d, resp;
        int          snap, n;

        reset_n      = 1'b0;
        cmd_valid    = 1'b0;
        cmd_write    = 1'b0;
        cmd_phy_addr = '0;
        cmd_reg_addr = '0;
        cmd_data     = '0;
        cmd_valid_b  = 1'b0;
        cmd_write_b  = 1'b0;
        cmd_phy_addr_b = '0;
        cmd_reg_addr_b = '0;
        cmd_data_b   = '0;
        mdio_i_b     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_data", rsp_data, 16'h0000);
        check("rst_rsp_error", rsp_error, 1'b0);
        check("rst_mdc", mdc_o, 1'b0);
        check("rst_mdio_o", mdio_o, 1'b1);
        check("rst_mdio_t", mdio_t, 1'b1);
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", cmd_ready, 1'b1);

        run_frame(1'b1, 5'd1, 5'd0, 16'h1140, 1'b0, 16'h0000, "wr_1140");
        run_frame(1'b0, 5'd1, 5'd1, 16'h0000, 1'b1, 16'h796D, "rd_796d");
        run_frame(1'b1, 5'($urandom), 5'($urandom), 16'($urandom), 1'b0, 16'h0000, "wr_rand");
        run_frame(1'b0, 5'($urandom), 5'($urandom), 16'($urandom), 1'b1, 16'($urandom), "rd_rand");
        run_frame(1'b0, 5'($urandom), 5'($urandom), 16'($urandom), 1'b0, 16'h0000, "rd_nophy");

        // Back-to-back: cmd_valid stays high with churning fields while busy.
        pa = 5'($urandom); ra = 5'($urandom); d = 16'($urandom);
        pa2 = 5'($urandom); ra2 = 5'($urandom); resp = 16'($urandom);
        phy_read = 1'b0;
        cmd_write = 1'b1; cmd_phy_addr = pa; cmd_reg_addr = ra; cmd_data = d;
        cmd_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!rsp_valid) begin
                cmd_write    = 1'($urandom);
                cmd_phy_addr = 5'($urandom);
                cmd_reg_addr = 5'($urandom);
                cmd_data     = 16'($urandom);
            end
        end while (!rsp_valid && n < 4000);
        check("b2b_first_rsp_seen", rsp_valid, 1'b1);
        check_frame(1'b1, pa, ra, d, 1'b0, 16'h0000, "b2b_first");
        cmd_write = 1'b0; cmd_phy_addr = pa2; cmd_reg_addr = ra2; cmd_data = 16'($urandom);
        phy_read = 1'b1; phy_present = 1'b1; phy_resp = resp;
        @(negedge clk);
        check("b2b_ready_idle", cmd_ready, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("b2b_accept_cycle", acc_cyc, rsp_cyc + 1);
        wait_rsp("b2b_second");
        check_frame(1'b0, pa2, ra2, 16'h0000, 1'b1, resp, "b2b_second");
        @(negedge clk);

        // Reset in the middle of a write frame.
        phy_read = 1'b0;
        issue(1'b1, 5'($urandom), 5'($urandom), 16'($urandom), "mid_rst");
        n = 0;
        while (nbits < 40 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("mid_rst_reached_bit40", nbits, 40);
        snap = rsp_cnt;
        reset_n = 1'b0;
        #1;
        check("mid_rst_mdc", mdc_o, 1'b0);
        check("mid_rst_mdio_t", mdio_t, 1'b1);
        check("mid_rst_mdio_o", mdio_o, 1'b1);
        check("mid_rst_ready", cmd_ready, 1'b0);
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("mid_rst_ready_release", cmd_ready, 1'b1);
        repeat (200) @(negedge clk);
        check("mid_rst_no_rsp", rsp_cnt - snap, 0);
        run_frame(1'b0, 5'($urandom), 5'($urandom), 16'h0000, 1'b1, 16'($urandom), "rd_after_rst");

        // DIV=2, no preamble: 32-bit frame, 4-clk MDC period.
        pa = 5'($urandom); ra = 5'($urandom); d = 16'($urandom);
        cmd_write_b = 1'b1; cmd_phy_addr_b = pa; cmd_reg_addr_b = ra; cmd_data_b = d;
        cmd_valid_b = 1'b1;
        @(negedge clk);
        cmd_valid_b = 1'b0;
        n = 0;
        while (!rsp_valid_b && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("b_wr_rsp_seen", rsp_valid_b, 1'b1);
        check("b_wr_latency", rsp_cyc_b - acc_cyc_b, 129);
        check("b_wr_nbits", nbits_b, 32);
        check("b_wr_frame", cap_b, {2'b01, 2'b01, pa, ra, 2'b10, d});
        check("b_mdc_period", rise_gap_b, 4);
        @(negedge clk);
        cmd_write_b = 1'b0; cmd_phy_addr_b = 5'($urandom); cmd_reg_addr_b = 5'($urandom);
        cmd_valid_b = 1'b1;
        @(negedge clk);
        cmd_valid_b = 1'b0;
        n = 0;
        while (!rsp_valid_b && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("b_rd_rsp_seen", rsp_valid_b, 1'b1);
        check("b_rd_latency", rsp_cyc_b - acc_cyc_b, 129);
        check("b_rd_data", rsp_data_b, 16'h0000);
        check("b_rd_error", rsp_error_b, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
